shift_add_mult_ctrl: RTL and testbench

- Sequential 4x4 multiplier controller that time-shares one fourBitAdder instance over 4 add/shift iterations.
- Sits in the behavioural multiplier path as the iterative alternative to an array multiplier.
- Start/busy/done handshake; product held stable until the next accepted start.

---
 rtl/shift_add_mult_ctrl_pkg.sv | 15 +
 rtl/shift_add_mult_ctrl_adder.sv | 26 ++
 rtl/shift_add_mult_ctrl.sv | 121 ++++++++++++
 tb/tb_shift_add_mult_ctrl.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/shift_add_mult_ctrl_pkg.sv
// Shared constants for the iterative 4x4 shift/add multiplier.
// Optional build macro BOOTH_SIGNED_EN selects radix-2 Booth (signed) mode.
package shift_add_mult_ctrl_pkg;

  localparam int MULT_W     = 4;       // operand width, fixed by fourBitAdder
  localparam int ITER_LIMIT = MULT_W;  // one add/shift pair per multiplier bit

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ADD   = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/shift_add_mult_ctrl_adder.sv
// fourBitAdder: ripple-carry adder with built-in subtract (a - b = a + ~b + 1).
module fourBitAdder
  import shift_add_mult_ctrl_pkg::*;
(
  input  logic [MULT_W-1:0] a,
  input  logic [MULT_W-1:0] b,
  input  logic              cin0,
  input  logic              subtract,
  output logic [MULT_W-1:0] sum,
  output logic              cout
);

  logic [MULT_W-1:0] b_eff;
  logic [MULT_W:0]   c;

  assign b_eff = b ^ {MULT_W{subtract}};
  assign c[0]  = cin0 ^ subtract;

  for (genvar i = 0; i < MULT_W; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b_eff[i] ^ c[i];
    assign c[i+1]   = (a[i] & b_eff[i]) | (c[i] & (a[i] ^ b_eff[i]));
  end

  assign cout = c[MULT_W];

endmodule

// File: rtl/shift_add_mult_ctrl.sv
// Iterative 4x4 multiplier: one shared fourBitAdder, WIDTH add/shift passes.
// Define BOOTH_SIGNED_EN for radix-2 Booth signed operation; default is unsigned.
module shift_add_mult_ctrl
  import shift_add_mult_ctrl_pkg::*;
#(
  parameter int WIDTH  = MULT_W,
  parameter int ITER_W = 3
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  state_t              state, state_nxt;
  logic [WIDTH-1:0]    mcand, hi, lo, sum;
  logic                e, cout, sub, do_op, ext, fill;
  logic [ITER_W-1:0]   count, count_inc;
  logic [2*WIDTH-1:0]  prod_q;

  assign count_inc = count + 1'b1;

`ifdef BOOTH_SIGNED_EN
  logic q;
  // Booth pair {lo[0],q}: 10 subtract, 01 add, 00/11 skip.
  assign sub   = lo[0] & ~q;
  assign do_op = lo[0] ^ q;
  // True sign of the 5-bit sum of sign-extended hi and (possibly inverted) mcand.
  assign ext   = hi[WIDTH-1] ^ (mcand[WIDTH-1] ^ sub) ^ cout;
  assign fill  = e;
`else
  assign sub   = 1'b0;
  assign do_op = lo[0];
  assign ext   = cout;
  assign fill  = 1'b0;
`endif

  fourBitAdder u_add (
    .a        (hi),
    .b        (mcand),
    .cin0     (1'b0),
    .subtract (sub),
    .sum      (sum),
    .cout     (cout)
  );

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next state and handshake outputs; product bypasses to {hi,lo} during DONE
  // so it is valid in the same cycle as the done pulse.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    product   = prod_q;
    case (state)
      IDLE:  if (start) state_nxt = ADD;
      ADD:   begin busy = 1'b1; state_nxt = SHIFT; end
      SHIFT: begin
        busy      = 1'b1;
        state_nxt = (count_inc == ITER_W'(ITER_LIMIT)) ? DONE : ADD;
      end
      DONE:  begin
        done      = 1'b1;
        product   = {hi, lo};
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Datapath: operand latch, conditional accumulate, right shift, result hold.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand  <= '0;
      e      <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      count  <= '0;
      prod_q <= '0;
`ifdef BOOTH_SIGNED_EN
      q      <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          mcand <= multiplicand;
          lo    <= multiplier;
          e     <= 1'b0;
          hi    <= '0;
          count <= '0;
`ifdef BOOTH_SIGNED_EN
          q     <= 1'b0;
`endif
        end
        ADD: if (do_op) begin
          hi <= sum;
          e  <= ext;
        end
        SHIFT: begin
          {e, hi, lo} <= {fill, e, hi, lo[WIDTH-1:1]};
`ifdef BOOTH_SIGNED_EN
          q           <= lo[0];
`endif
          count       <= count_inc;
        end
        DONE: prod_q <= {hi, lo};
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_add_mult_ctrl.sv
// Self-checking bench for shift_add_mult_ctrl (unsigned, or Booth when
// BOOTH_SIGNED_EN is defined for both bench and design).
module tb_shift_add_mult_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start;
  logic [3:0] multiplicand, multiplier;
  logic       busy, done;
  logic [7:0] product;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] last_prod;

  shift_add_mult_ctrl dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .done         (done),
    .product      (product)
  );

  always #5 clk = ~clk;

  // Reference: plain arithmetic on the operands, truncated to 8 bits.
  function automatic logic [7:0] ref_mult(input logic [3:0] a, input logic [3:0] b);
    int pa, pb;
`ifdef BOOTH_SIGNED_EN
    pa = int'($signed(a));
    pb = int'($signed(b));
`else
    pa = int'(a);
    pb = int'(b);
`endif
    return 8'(pa * pb);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full operation: start pulse, scrambled operands afterwards, then
  // latency, busy span, product-hold and result checks.
  task automatic run(input logic [3:0] a, input logic [3:0] b, input string tag);
    logic [7:0] exp;
    int         cyc, busy_cnt;
    bit         seen, hold_bad;
    exp = ref_mult(a, b);
    @(negedge clk);
    start = 1'b1; multiplicand = a; multiplier = b;
    @(negedge clk);
    start = 1'b0; multiplicand = 4'($urandom); multiplier = 4'($urandom);
    cyc = 1; busy_cnt = 0; seen = 0; hold_bad = 0;
    while (!seen && cyc <= 15) begin
      if (done === 1'b1) seen = 1;
      else begin
        if (busy === 1'b1) busy_cnt++;
        if (product !== last_prod) hold_bad = 1;
        cyc++;
        @(negedge clk);
      end
    end
    chk({tag, "_done_seen"}, int'(seen), 1);
    chk({tag, "_latency"}, cyc, 9);
    chk({tag, "_busy_cycles"}, busy_cnt, 8);
    chk({tag, "_busy_at_done"}, int'(busy), 0);
    chk({tag, "_prev_hold"}, int'(hold_bad), 0);
    chk({tag, "_product"}, int'(product), int'(exp));
    @(negedge clk);
    chk({tag, "_done_pulse"}, int'(done), 0);
    chk({tag, "_product_hold"}, int'(product), int'(exp));
    last_prod = exp;
  endtask

  initial begin
    logic [3:0] opa [0:30];
    logic [3:0] opb [0:30];
    int         dcount;

    reset_n = 1'b0; start = 1'b0; multiplicand = '0; multiplier = '0;
    last_prod = '0;
    repeat (2) @(negedge clk);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_product", int'(product), 0);
    reset_n = 1'b1;

`ifdef BOOTH_SIGNED_EN
    run(4'h8, 4'h8, "s_m8xm8");
    chk("s_m8xm8_const", int'(product), 8'h40);
    run(4'hD, 4'h5, "s_m3x5");
    chk("s_m3x5_const", int'(product), 8'hF1);
    run(4'h7, 4'h8, "s_7xm8");
    chk("s_7xm8_const", int'(product), 8'hC8);
    run(4'h0, 4'hF, "s_0xm1");
    chk("s_0xm1_const", int'(product), 8'h00);
    run(4'hF, 4'hF, "s_m1xm1");
    chk("s_m1xm1_const", int'(product), 8'h01);
`else
    run(4'hF, 4'hF, "u_FxF");
    chk("u_FxF_const", int'(product), 8'hE1);
    run(4'hD, 4'h5, "u_Dx5");
    chk("u_Dx5_const", int'(product), 8'h41);
    repeat (3) @(negedge clk);
    chk("u_idle_hold", int'(product), 8'h41);
    run(4'h0, 4'h9, "u_0x9");
    chk("u_0x9_const", int'(product), 8'h00);
`endif

    for (int i = 0; i < 8; i++)
      run(4'($urandom), 4'($urandom), $sformatf("rand%0d", i));

    // start held high with operands churning every cycle.
    dcount = 0;
    @(negedge clk);
    opa[0] = 4'($urandom); opb[0] = 4'($urandom);
    start = 1'b1; multiplicand = opa[0]; multiplier = opb[0];
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        dcount++;
        chk($sformatf("held_done_cycle%0d", c), c % 10, 9);
        if (c >= 9)
          chk($sformatf("held_product%0d", c), int'(product),
              int'(ref_mult(opa[c-9], opb[c-9])));
        last_prod = product;
      end
      opa[c] = 4'($urandom); opb[c] = 4'($urandom);
      multiplicand = opa[c]; multiplier = opb[c];
    end
    start = 1'b0;
    chk("held_done_count", dcount, 3);

    // Asynchronous reset in cycle 4 of an operation.
    @(negedge clk);
    start = 1'b1; multiplicand = 4'hB; multiplier = 4'h6;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_product", int'(product), 0);
    last_prod = '0;
    @(negedge clk);
    reset_n = 1'b1;
    dcount = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) dcount++;
    end
    chk("abort_no_done", dcount, 0);
    run(4'h3, 4'h3, "post_reset_3x3");
    chk("post_reset_const", int'(product), 8'h09);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
